axi_noc_wr_sf: RTL

Store-and-forward AXI4 write buffer between a tile interconnect's NoC-facing slave port and the NoC network-interface write channel. Collects a complete write burst (AW + all W beats) locally before issuing it downstream, so a NoC packet never stalls mid-burst on a slow core. Returns the downstream B response upstream. Oversize bursts are absorbed and answered with SLVERR. Read channels bypass this block.

---
 rtl/axi_noc_wr_sf.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axi_noc_wr_sf.sv
`default_nettype none
// ============================================================================
// Module   : axi_noc_wr_sf
// Purpose  : Store-and-forward AXI4 write buffer. Accepts a complete write
//            burst (AW plus every W beat) from the upstream slave port, then
//            replays it downstream towards the NoC network interface, so a
//            NoC packet never stalls in the middle of a burst. The downstream
//            B response is returned upstream. Bursts longer than MAX_BEATS
//            are absorbed and answered with SLVERR. Only one transaction is
//            in flight at a time.
// Ports    : clk, arst (synchronous, active-high)
//            s_aw*/s_w*/s_b*  upstream write address / data / response
//            m_aw*/m_w*/m_b*  downstream write address / data / response
//            busy             high whenever the FSM is not in IDLE
//            wlast_err        sticky flag: upstream wlast disagreed with awlen
// Revision : 1.0 - initial release
// ============================================================================
module axi_noc_wr_sf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  output logic                    busy,
  output logic                    wlast_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int ENT_WIDTH  = DATA_WIDTH + STRB_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    DRAIN   = 3'd2,
    SEND_AW = 3'd3,
    SEND_W  = 3'd4,
    WAIT_B  = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            wr_cnt;
  logic [7:0]            rd_cnt, rd_cnt_nxt;
  logic [1:0]            bresp_q;
  logic [ENT_WIDTH-1:0]  mem [MAX_BEATS];
  logic [ENT_WIDTH-1:0]  rd_q;

  logic [8:0]            aw_beats;
  logic                  oversize;
  logic                  w_is_last;
  logic                  w_take;

  assign aw_beats  = {1'b0, s_awlen} + 9'd1;
  assign oversize  = aw_beats > 9'(MAX_BEATS);
  // The beat count, not s_wlast, decides where the burst ends.
  assign w_is_last = (wr_cnt == len_q);
  assign w_take    = ((state == COLLECT) || (state == DRAIN)) && s_wvalid;

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_awvalid) state_nxt = oversize ? DRAIN : COLLECT;
      COLLECT: if (s_wvalid && w_is_last) state_nxt = SEND_AW;
      DRAIN:   if (s_wvalid && w_is_last) state_nxt = RESP;
      SEND_AW: if (m_awready) state_nxt = SEND_W;
      SEND_W:  if (m_wready && (rd_cnt == len_q)) state_nxt = WAIT_B;
      WAIT_B:  if (m_bvalid) state_nxt = RESP;
      RESP:    if (s_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read pointer for the following cycle; the buffer read is registered
  // against this so m_wdata holds still while m_wready is low.
  always_comb begin
    rd_cnt_nxt = rd_cnt;
    if (state == SEND_AW)
      rd_cnt_nxt = 8'd0;
    else if ((state == SEND_W) && m_wready)
      rd_cnt_nxt = rd_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      addr_q    <= '0;
      len_q     <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      bresp_q   <= '0;
      wlast_err <= 1'b0;
    end else begin
      rd_cnt <= rd_cnt_nxt;
      if ((state == IDLE) && s_awvalid) begin
        addr_q <= s_awaddr;
        len_q  <= s_awlen;
        wr_cnt <= '0;
      end
      if (w_take) begin
        wr_cnt <= wr_cnt + 8'd1;
        if (s_wlast != w_is_last) wlast_err <= 1'b1;
        if ((state == DRAIN) && w_is_last) bresp_q <= 2'b10;
      end
      if ((state == WAIT_B) && m_bvalid) bresp_q <= m_bresp;
    end
  end

  // Beat buffer: not reset, contents only matter once written.
  always_ff @(posedge clk) begin
    if (!arst && (state == COLLECT) && s_wvalid)
      mem[wr_cnt[IDX_WIDTH-1:0]] <= {s_wdata, s_wstrb};
    rd_q <= mem[rd_cnt_nxt[IDX_WIDTH-1:0]];
  end

  // Outputs: everything forced low while reset is asserted; payloads are
  // only driven alongside their valid.
  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    busy      = 1'b0;
    if (!arst) begin
      busy = (state != IDLE);
      case (state)
        IDLE:    s_awready = 1'b1;
        COLLECT: s_wready  = 1'b1;
        DRAIN:   s_wready  = 1'b1;
        SEND_AW: begin
          m_awvalid = 1'b1;
          m_awaddr  = addr_q;
          m_awlen   = len_q;
        end
        SEND_W: begin
          m_wvalid = 1'b1;
          m_wdata  = rd_q[ENT_WIDTH-1:STRB_WIDTH];
          m_wstrb  = rd_q[STRB_WIDTH-1:0];
          m_wlast  = (rd_cnt == len_q);
        end
        WAIT_B:  m_bready = 1'b1;
        RESP: begin
          s_bvalid = 1'b1;
          s_bresp  = bresp_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
